// File: rtl/tx_stream_pkg.sv
// Shared types and constants for the tx frame streamer.
// The CKSUM state exists only when TX_STREAM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
package tx_stream_pkg;

  localparam int FRAME_ROWS = 30;
  localparam int FRAME_COLS = 170;
  localparam int DEF_BYTES_PER_FRAME = FRAME_ROWS * FRAME_COLS;
  localparam logic [7:0] DEF_SOF0 = 8'hAA;
  localparam logic [7:0] DEF_SOF1 = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
`ifdef TX_STREAM_CHECKSUM_EN
    CKSUM,
`endif
    FINISH
  } state_e;

  typedef enum logic [1:0] {
    LOAD,
    WAIT_ACK,
    WAIT_DONE
  } phase_e;

endpackage

// File: rtl/uart_byte_sender.sv
// One-byte handshake with uart_tx: LOAD -> WAIT_ACK -> WAIT_DONE.
// load_fire marks the LOAD cycle in which byte_in is captured.
`timescale 1ns/1ps
module uart_byte_sender
  import tx_stream_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       byte_done,
  output logic       load_fire
);

  phase_e phase, phase_nxt;

  always_comb begin
    phase_nxt = phase;
    load_fire = 1'b0;
    byte_done = 1'b0;
    case (phase)
      LOAD: begin
        // a uart still busy from elsewhere stalls us here with no pulse
        if (send_req && !tx_busy) begin
          load_fire = 1'b1;
          phase_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) phase_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          phase_nxt = LOAD;
        end
      end
      default: phase_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= LOAD;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      phase    <= phase_nxt;
      tx_start <= load_fire;
      if (load_fire) tx_data <= byte_in;
    end
  end

endmodule

// File: rtl/tx_frame_streamer.sv
// Streams SOF0, SOF1, the tx_ram payload and (with TX_STREAM_CHECKSUM_EN)
// a mod-256 payload checksum to uart_tx, one frame per frame_done rise.
`timescale 1ns/1ps
module tx_frame_streamer
  import tx_stream_pkg::*;
#(
  parameter int         BYTES_PER_FRAME = DEF_BYTES_PER_FRAME,
  parameter logic [7:0] SOF0            = DEF_SOF0,
  parameter logic [7:0] SOF1            = DEF_SOF1,
  parameter int         CNT_W           = $clog2(BYTES_PER_FRAME)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_done,
  input  logic [7:0] rData,
  output logic       re,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       stream_done,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_FRAME - 1);

  state_e           state, state_nxt;
  logic             fd_q;
  logic             armed;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             send_req;
  logic [7:0]       byte_sel;
  logic             byte_done;
  logic             load_fire;
`ifdef TX_STREAM_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  // armed keeps a level already high across reset release from looking like an edge
  assign rise = frame_done & ~fd_q & armed;

  uart_byte_sender u_sender (
    .clk       (clk),
    .reset     (reset),
    .send_req  (send_req),
    .byte_in   (byte_sel),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .byte_done (byte_done),
    .load_fire (load_fire)
  );

  always_comb begin
    state_nxt = state;
    send_req  = 1'b0;
    byte_sel  = SOF0;
    case (state)
      IDLE: begin
        if (rise) state_nxt = HDR0;
      end
      HDR0: begin
        send_req = 1'b1;
        byte_sel = SOF0;
        if (byte_done) state_nxt = HDR1;
      end
      HDR1: begin
        send_req = 1'b1;
        byte_sel = SOF1;
        if (byte_done) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        send_req = 1'b1;
        byte_sel = rData;
        if (byte_done && cnt == LAST) begin
`ifdef TX_STREAM_CHECKSUM_EN
          state_nxt = CKSUM;
`else
          state_nxt = FINISH;
`endif
        end
      end
`ifdef TX_STREAM_CHECKSUM_EN
      CKSUM: begin
        send_req = 1'b1;
        byte_sel = sum;
        if (byte_done) state_nxt = FINISH;
      end
`endif
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // rData is captured on the same edge that advances tx_ram's read counter
  assign re          = load_fire && (state == PAYLOAD);
  assign busy        = (state != IDLE) && (state != FINISH);
  assign stream_done = (state == FINISH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      fd_q    <= 1'b0;
      armed   <= 1'b0;
      overrun <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      fd_q  <= frame_done;
      armed <= 1'b1;
      if (rise && state != IDLE) overrun <= 1'b1;
      if (state == IDLE) cnt <= '0;
      else if (state == PAYLOAD && byte_done) cnt <= cnt + 1'b1;
    end
  end

`ifdef TX_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum <= 8'h00;
    else if (state == IDLE && rise) sum <= 8'h00;
    else if (re) sum <= sum + rData;
  end
`endif

endmodule

// File: tb/tb_tx_frame_streamer.sv
// Bench for tx_frame_streamer: tx_ram and uart_tx models plus a frame-level reference.
`timescale 1ns/1ps
module tb_tx_frame_streamer;

  localparam int N = 5100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_done = 1'b0;
  logic       hold_busy = 1'b0;
  logic [7:0] rData;
  logic       re;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       busy;
  logic       stream_done;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tx_frame_streamer dut (
    .clk         (clk),
    .reset       (reset),
    .frame_done  (frame_done),
    .rData       (rData),
    .re          (re),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .stream_done (stream_done),
    .overrun     (overrun)
  );

  // tx_ram: combinational read at an internal counter, reset with the system
  logic [7:0] ram [N];
  int rcnt = 0;
  int re_total = 0;
  assign rData = ram[rcnt];
  always @(posedge clk or negedge reset) begin
    if (!reset) rcnt <= 0;
    else if (re) rcnt <= (rcnt == N - 1) ? 0 : rcnt + 1;
  end
  always @(posedge clk) if (re) re_total <= re_total + 1;

  // uart_tx: busy rises the cycle after tx_start and stays for busy_len cycles
  logic [7:0] wire_q[$];
  logic [7:0] exp_q[$];
  int   busy_cnt = 0;
  int   busy_len = 1;
  bit   busy_rand = 1'b0;
  int   done_total = 0;
  int   proto_err = 0;
  logic start_q = 1'b0;
  always @(posedge clk) begin
    if (tx_start) begin
      wire_q.push_back(tx_data);
      if (tx_busy || start_q) proto_err <= proto_err + 1;
      busy_cnt <= busy_rand ? int'($urandom_range(2, 1)) : busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    start_q <= tx_start;
    if (stream_done) done_total <= done_total + 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  int fr_base, fr_rb, fr_db;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected wire image of one frame from the current RAM contents
  function automatic void build_expected();
    int sum = 0;
    exp_q.delete();
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back(ram[k]);
      sum += int'(ram[k]);
    end
`ifdef TX_STREAM_CHECKSUM_EN
    exp_q.push_back(8'(sum));
`endif
  endfunction

  function automatic int stream_diffs(input int base);
    int d = 0;
    if (wire_q.size() - base != exp_q.size()) return -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (wire_q[base + i] !== exp_q[i]) d++;
    return d;
  endfunction

  task automatic wait_done(input int limit, output bit ok, output logic busy_at);
    ok = 1'b0;
    busy_at = 1'bx;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (stream_done) begin
        ok = 1'b1;
        busy_at = busy;
      end
    end
  endtask

  task automatic wait_re(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (re_total >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0;
    frame_done = 1'b1;
    repeat (3) tick();
    tests++;
    if ({re, tx_start, busy, stream_done, overrun} !== 5'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_outputs: got re=%b start=%b busy=%b done=%b ovr=%b data=%h want all 0",
               re, tx_start, busy, stream_done, overrun, tx_data);
    end
    reset = 1'b1;
    base = wire_q.size();
    repeat (20) tick();
    tests++;
    if (busy !== 1'b0 || wire_q.size() != base) begin
      fails++;
      $display("FAIL reset_held_level: got busy=%b bytes=%0d want busy=0 bytes=0", busy, wire_q.size() - base);
    end
    frame_done = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    int base, rb, db;
    bit ok;
    logic bd;
    for (int k = 0; k < N; k++) ram[k] = 8'(k);
    build_expected();
    busy_rand = 1'b1;
    base = wire_q.size(); rb = re_total; db = done_total;
    frame_done = 1'b1;
    tick();
    tests++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL trigger_cycle: got start=%b busy=%b want start=0 busy=1", tx_start, busy);
    end
    tick();
    tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin
      fails++;
      $display("FAIL sof0_latency: got start=%b data=%h want start=1 data=aa", tx_start, tx_data);
    end
    wait_done(40000, ok, bd);
    tests++;
    if (!ok) begin fails++; $display("FAIL stream_timeout: got no stream_done want one"); end
    tests++;
    if (bd !== 1'b0) begin fails++; $display("FAIL busy_at_done: got %b want 0", bd); end
    tests++;
    if (stream_diffs(base) != 0) begin
      fails++;
      $display("FAIL stream_bytes: got %0d bytes diffs=%0d want %0d bytes diffs=0",
               wire_q.size() - base, stream_diffs(base), exp_q.size());
    end
    tests++;
    if (re_total - rb != N) begin fails++; $display("FAIL stream_re_count: got %0d want %0d", re_total - rb, N); end
    tests++;
    if (rcnt != 0) begin fails++; $display("FAIL ram_wrap: got %0d want 0", rcnt); end
    repeat (20) tick();
    tests++;
    if (done_total - db != 1) begin fails++; $display("FAIL done_count: got %0d want 1", done_total - db); end
    tests++;
    if (overrun !== 1'b0 || busy !== 1'b0 || proto_err != 0) begin
      fails++;
      $display("FAIL stream_after: got ovr=%b busy=%b proto=%0d want 0 0 0", overrun, busy, proto_err);
    end
    frame_done = 1'b0;
    busy_rand = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int starts = 0;
    for (int k = 0; k < N; k++) ram[k] = 8'($urandom);
    build_expected();
    busy_len = 1;
    hold_busy = 1'b1;
    tick();
    fr_base = wire_q.size(); fr_rb = re_total; fr_db = done_total;
    frame_done = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_start) starts++;
    end
    tests++;
    if (starts != 0) begin fails++; $display("FAIL stall_no_start: got %0d starts want 0", starts); end
    hold_busy = 1'b0;
    tick();
    tests++;
    if (tx_start !== 1'b1 || tx_data !== 8'hAA) begin
      fails++;
      $display("FAIL stall_release: got start=%b data=%h want start=1 data=aa", tx_start, tx_data);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic bd;
    int base;
    wait_re(fr_rb + 300, 5000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL overrun_reach: got re=%0d want 300", re_total - fr_rb); end
    frame_done = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    tests++;
    if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %b want 1", overrun); end
    wait_done(40000, ok, bd);
    tests++;
    if (!ok || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_frame_end: got done=%b ovr=%b want 1 1", ok, overrun);
    end
    tests++;
    if (re_total - fr_rb != N || stream_diffs(fr_base) != 0) begin
      fails++;
      $display("FAIL overrun_stream: got re=%0d diffs=%0d want re=%0d diffs=0",
               re_total - fr_rb, stream_diffs(fr_base), N);
    end
    base = wire_q.size();
    repeat (30) tick();
    tests++;
    if (wire_q.size() != base || busy !== 1'b0 || done_total - fr_db != 1 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_no_restart: got bytes=%0d busy=%b dones=%0d ovr=%b want 0 0 1 1",
               wire_q.size() - base, busy, done_total - fr_db, overrun);
    end
  endtask

  task automatic test_reset_mid();
    int base, rb, db;
    bit ok;
    logic bd;
    for (int k = 0; k < N; k++) ram[k] = 8'h01;
    build_expected();
    frame_done = 1'b0;
    tick();
    rb = re_total;
    frame_done = 1'b1;
    wait_re(rb + 100, 2000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midreset_reach: got re=%0d want 100", re_total - rb); end
    reset = 1'b0;
    #2;
    tests++;
    if ({re, tx_start, busy, stream_done, overrun} !== 5'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL midreset_outputs: got re=%b start=%b busy=%b done=%b ovr=%b data=%h want all 0",
               re, tx_start, busy, stream_done, overrun, tx_data);
    end
    tick(); tick();
    reset = 1'b1;
    repeat (5) tick();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL midreset_no_retrigger: got busy=%b want 0", busy); end
    frame_done = 1'b0;
    tick();
    base = wire_q.size(); rb = re_total; db = done_total;
    frame_done = 1'b1;
    wait_done(40000, ok, bd);
    tests++;
    if (!ok || stream_diffs(base) != 0) begin
      fails++;
      $display("FAIL restart_stream: got done=%b bytes=%0d diffs=%0d want done=1 bytes=%0d diffs=0",
               ok, wire_q.size() - base, stream_diffs(base), exp_q.size());
    end
    tests++;
    if (re_total - rb != N || rcnt != 0) begin
      fails++;
      $display("FAIL restart_re: got re=%0d ptr=%0d want %0d 0", re_total - rb, rcnt, N);
    end
    tests++;
    if (wire_q[base + exp_q.size() - 1] !== exp_q[exp_q.size() - 1]) begin
      fails++;
      $display("FAIL restart_last_byte: got %h want %h",
               wire_q[base + exp_q.size() - 1], exp_q[exp_q.size() - 1]);
    end
    repeat (5) tick();
    tests++;
    if (done_total - db != 1 || proto_err != 0) begin
      fails++;
      $display("FAIL restart_done: got dones=%0d proto=%0d want 1 0", done_total - db, proto_err);
    end
    frame_done = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) ram[k] = 8'h00;
    test_reset();
    test_stream();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
